// File: rtl/csr_unit.sv
// Machine-mode CSR file for the single-cycle RV32I core.
// Holds mstatus/mie/mtvec/mscratch/mepc/mcause/mtval, the 64-bit
// mcycle/minstret counters, trap entry and mret restore.
// Optional build macro: CSR_USER_COUNTERS_EN adds the read-only user
// counter shadows (cycle/instret and their high halves).
module csr_unit #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    input  logic        csr_write_enable,
    input  logic [1:0]  csr_op,
    input  logic [2:0]  csr_funct3,
    input  logic [4:0]  csr_imm,
    input  logic [31:0] rs1_data,
    input  logic        instr_retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret,
    output logic [31:0] csr_rdata,
    output logic        illegal_csr,
    output logic [31:0] trap_vector,
    output logic [31:0] epc_out,
    output logic        mie_global
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
`ifdef CSR_USER_COUNTERS_EN
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_SET   = 2'd1,
        OP_CLR   = 2'd2
    } csr_kind_e;

    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]  mie_en_q,       mie_en_d;      // MSIE, MTIE, MEIE
    logic [31:0] mtvec_q,        mtvec_d;
    logic [31:0] mscratch_q,     mscratch_d;
    logic [31:0] mepc_q,         mepc_d;
    logic [31:0] mcause_q,       mcause_d;
    logic [31:0] mtval_q,        mtval_d;
    logic [63:0] mcycle_q,       mcycle_d;
    logic [63:0] minstret_q,     minstret_d;

    csr_kind_e   kind;
    logic [31:0] operand;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        mapped;
    logic        read_only;
    logic        do_write;
    logic        wr_en;

    // Decode the operation kind and select the source operand.
    always_comb begin
        kind    = OP_WRITE;
        operand = rs1_data;
        if (csr_op == 2'b11) begin
            operand = {27'd0, csr_imm};
            unique case (csr_funct3)
                3'b110:  kind = OP_SET;
                3'b111:  kind = OP_CLR;
                default: kind = OP_WRITE;
            endcase
        end else begin
            unique case (csr_op)
                2'b01:   kind = OP_SET;
                2'b10:   kind = OP_CLR;
                default: kind = OP_WRITE;
            endcase
        end
    end

    // Address decode: current value, whether mapped, whether read-only.
    always_comb begin
        mapped    = 1'b1;
        read_only = 1'b0;
        old_val   = 32'd0;
        unique case (csr_addr)
            ADDR_MSTATUS:   old_val = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            ADDR_MISA:      begin read_only = 1'b1; old_val = MISA_VALUE; end
            ADDR_MIE:       old_val = {20'd0, mie_en_q[2], 3'd0, mie_en_q[1], 3'd0, mie_en_q[0], 3'd0};
            ADDR_MTVEC:     old_val = mtvec_q;
            ADDR_MSCRATCH:  old_val = mscratch_q;
            ADDR_MEPC:      old_val = mepc_q;
            ADDR_MCAUSE:    old_val = mcause_q;
            ADDR_MTVAL:     old_val = mtval_q;
            ADDR_MIP:       old_val = 32'd0;
            ADDR_MCYCLE:    old_val = mcycle_q[31:0];
            ADDR_MCYCLEH:   old_val = mcycle_q[63:32];
            ADDR_MINSTRET:  old_val = minstret_q[31:0];
            ADDR_MINSTRETH: old_val = minstret_q[63:32];
            ADDR_MVENDORID,
            ADDR_MARCHID,
            ADDR_MIMPID:    read_only = 1'b1;
            ADDR_MHARTID:   begin read_only = 1'b1; old_val = HART_ID; end
`ifdef CSR_USER_COUNTERS_EN
            ADDR_CYCLE:     begin read_only = 1'b1; old_val = mcycle_q[31:0]; end
            ADDR_CYCLEH:    begin read_only = 1'b1; old_val = mcycle_q[63:32]; end
            ADDR_INSTRET:   begin read_only = 1'b1; old_val = minstret_q[31:0]; end
            ADDR_INSTRETH:  begin read_only = 1'b1; old_val = minstret_q[63:32]; end
`endif
            default:        mapped = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read: no write, no read-only fault.
    always_comb begin
        do_write    = csr_write_enable & ((kind == OP_WRITE) | (operand != 32'd0));
        illegal_csr = csr_write_enable & (~mapped | (read_only & do_write));
        csr_rdata   = (csr_write_enable & mapped & ~illegal_csr) ? old_val : 32'd0;
        wr_en       = do_write & ~illegal_csr & ~trap_valid;
        unique case (kind)
            OP_SET:  new_val = old_val | operand;
            OP_CLR:  new_val = old_val & ~operand;
            default: new_val = operand;
        endcase
    end

    // Next state: counters, CSR writes, then trap/mret which override mstatus.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_en_d       = mie_en_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + {63'd0, instr_retire};

        if (wr_en) begin
            unique case (csr_addr)
                ADDR_MSTATUS: begin
                    if (!mret) begin
                        mstatus_mie_d  = new_val[3];
                        mstatus_mpie_d = new_val[7];
                    end
                end
                ADDR_MIE:       mie_en_d   = {new_val[11], new_val[7], new_val[3]};
                ADDR_MTVEC:     mtvec_d    = new_val & ~32'h3;
                ADDR_MSCRATCH:  mscratch_d = new_val;
                ADDR_MEPC:      mepc_d     = new_val & ~32'h3;
                ADDR_MCAUSE:    mcause_d   = new_val;
                ADDR_MTVAL:     mtval_d    = new_val;
                ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], new_val};
                ADDR_MCYCLEH:   mcycle_d   = {new_val, mcycle_q[31:0]};
                ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], new_val};
                ADDR_MINSTRETH: minstret_d = {new_val, minstret_q[31:0]};
                default: ;
            endcase
        end

        if (trap_valid) begin
            mepc_d         = trap_pc & ~32'h3;
            mcause_d       = trap_cause;
            mtval_d        = trap_val;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_en_q       <= 3'd0;
            mtvec_q        <= MTVEC_RESET & ~32'h3;
            mscratch_q     <= 32'd0;
            mepc_q         <= 32'd0;
            mcause_q       <= 32'd0;
            mtval_q        <= 32'd0;
            mcycle_q       <= 64'd0;
            minstret_q     <= 64'd0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_en_q       <= mie_en_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    assign trap_vector = mtvec_q;
    assign epc_out     = mepc_q;
    assign mie_global  = mstatus_mie_q;

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR register file for the single-cycle RV32I core; sits directly downstream of the control unit.
- Consumes the decoded CSR controls (address, write enable, op, 5-bit immediate, funct3) plus rs1 data, and returns the old CSR value for rd writeback.
- Owns the 64-bit cycle/instret counters, trap-entry state (mepc/mcause/mtval/mstatus) and mret restore.
- Exports trap vector and return PC to the PC-select logic.

Parameters:
- HART_ID, 32'd0, value returned by mhartid (0xF14).
- MTVEC_RESET, 32'h0000_0000, mtvec reset value; bits[1:0] forced 0.
- MISA_VALUE, 32'h4000_0100, read-only misa (RV32I).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- csr_addr  in  12  CSR address from control unit.
- csr_write_enable  in  1  CSR instruction valid this cycle (asserted for every Zicsr op).
- csr_op  in  2  00 RW, 01 RS, 10 RC, 11 immediate variant.
- csr_funct3  in  3  distinguishes immediate variants: 101 RWI, 110 RSI, 111 RCI.
- csr_imm  in  5  zero-extended uimm for immediate variants.
- rs1_data  in  32  register operand for RW/RS/RC.
- instr_retire  in  1  one instruction retires this cycle.
- trap_valid  in  1  take trap at this edge.
- trap_cause  in  32  value for mcause.
- trap_pc  in  32  faulting PC.
- trap_val  in  32  value for mtval.
- mret  in  1  mret executing.
- csr_rdata  out  32  old CSR value (combinational).
- illegal_csr  out  1  access fault (combinational).
- trap_vector  out  32  mtvec with bits[1:0]=0.
- epc_out  out  32  mepc.
- mie_global  out  1  mstatus.MIE.

Behaviour:
- Read: csr_rdata = pre-write value of the addressed CSR, combinational. Reads 0 when csr_write_enable=0 or address unmapped.
- Operand: op=11 uses {27'b0, csr_imm}; otherwise rs1_data.
- New value:
  - RW/RWI: operand.
  - RS/RSI: old | operand.
  - RC/RCI: old & ~operand.
  - Written at the rising edge.
- Write suppression: RS/RC/RSI/RCI with operand==0 perform no write and no read-only check (approximates rs1=x0 / uimm=0 rule).
- Map (address: behaviour, reset value):
  - 0x300 mstatus: MIE bit3 and MPIE bit7 writable; MPP[12:11] reads 2'b11; other bits 0. Reset 0x0000_1800.
  - 0x301 misa: read-only. Reset MISA_VALUE.
  - 0x304 mie: bits 3, 7, 11 writable; others 0. Reset 0.
  - 0x305 mtvec: direct mode, bits[1:0] read 0. Reset MTVEC_RESET.
  - 0x340 mscratch: full 32 bits. Reset 0.
  - 0x341 mepc: bits[1:0] read 0. Reset 0.
  - 0x342 mcause, 0x343 mtval: full 32 bits. Reset 0.
  - 0x344 mip: reads 0; writes ignored, not illegal.
  - 0xB00/0xB80 mcycle lo/hi, 0xB02/0xB82 minstret lo/hi: writable. Reset 0.
  - 0xF11–0xF13: read 0. 0xF14: reads HART_ID. All four read-only.
- illegal_csr = csr_write_enable & (unmapped address | actual write to a read-only CSR). When illegal: no state change; csr_rdata=0.
- Counters:
  - mcycle +1 every cycle out of reset.
  - minstret +1 when instr_retire.
  - 64-bit wrap 0xFFFF_FFFF_FFFF_FFFF → 0.
  - A CSR write to either half of a counter replaces that half; that entire counter does not increment that cycle.
- Trap (trap_valid=1), at the edge:
  - mepc ← trap_pc & ~3; mcause ← trap_cause; mtval ← trap_val.
  - MPIE ← MIE; MIE ← 0.
  - Any simultaneous CSR write is dropped; counters still update.
- mret (without trap_valid): MIE ← MPIE; MPIE ← 1. trap_valid has priority over mret.
- mret plus CSR write to mstatus in the same cycle: mret wins; other CSR writes proceed.
- Reset asserted mid-operation: all registers return to reset values asynchronously; no pending write survives.
- Outputs at reset: csr_rdata=0 (no access), illegal_csr=0, trap_vector=MTVEC_RESET&~3, epc_out=0, mie_global=0.

Optional Feature:
- Macro CSR_USER_COUNTERS_EN.
- Defined: read-only shadows cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82 return the live counter halves; writes flag illegal_csr.
- Undefined: these addresses are unmapped and illegal_csr=1 on any access.

Test Plan:
- Reset release, then CSRRW 0x340 with rs1_data=0xDEADBEEF → csr_rdata=0 that cycle; next CSRRS 0x340 operand 0 returns 0xDEADBEEF, no write.
- mscratch=0xFF00FF00, CSRRCI uimm=0x1F → rdata 0xFF00FF00, new value 0xFF00FF00; CSRRSI uimm=0x0F → 0xFF00FF0F.
- CSRRW 0xF14 with rs1_data=5 → illegal_csr=1, mhartid unchanged. CSRRS 0xF14 operand 0 → rdata=HART_ID, illegal_csr=0. Access to 0x7C0 → illegal_csr=1, rdata=0.
- Write mcycle lo=0xFFFF_FFFE: that cycle no increment; two cycles later mcycleh=1, mcycle lo=0x0000_0000.
- MIE=1, trap_valid with trap_pc=0x1003, trap_cause=0xB, same-cycle CSRRW mscratch → mepc=0x1000, mcause=0xB, MIE=0, MPIE=1, mscratch unchanged. Then mret → MIE=1, MPIE=1, epc_out=0x1000.
- Assert rst_n=0 mid-cycle after writes → mtvec=MTVEC_RESET, mstatus=0x1800, counters=0 immediately, without waiting for a clk edge.
